conv_window_scheduler: RTL and testbench

Sequencer for the 3x3 convolution datapath. It walks a p x p row-major input image, stored at input-RAM addresses 0..p*p-1, with a 3x3 window. For every valid output position it issues the pixel read addresses and the window-shift strobes, triggers the result latch, and writes the result to output address r*(p-2)+c. It sits between the input handler (RAM-full indication) and the convolution datapath and output RAM, and replaces ad-hoc address generation in the control unit.

---
 rtl/conv_window_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// Sequencer that walks a 3x3 window over a P x P image, issuing read addresses, shift/load strobes and output writes.
// Optional build macro CONV_COL_REUSE_EN: for c>0 only the new window column is fetched.
module conv_window_scheduler #(
  parameter int P = 5,
  parameter int M = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_full,
  output logic [M-1:0] pixadr,
  output logic         rd_in,
  output logic         sh,
  output logic         load,
  output logic         wr_out,
  output logic [M-1:0] outadr,
  output logic         busy,
  output logic         done
);

  // state | meaning
  // IDLE  | wait for start with a full input RAM
  // FETCH | one pixel read per cycle, N reads per output
  // DRAIN | last registered pixel shifts into the window
  // CALC  | latch MAC result
  // WRITE | write result to output RAM, advance r/c
  // FIN   | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CALC, WRITE, FIN} state_t;

  localparam logic [M-1:0] P_W    = M'(P);
  localparam logic [M-1:0] RC_MAX = M'(P - 3);
  localparam logic [M-1:0] OUT_W  = M'(P - 2);

  state_t       state_q, state_d;
  logic [M-1:0] r_q, r_d;
  logic [M-1:0] c_q, c_d;
  logic [3:0]   k_q, k_d;
  logic [M-1:0] pixadr_q, pixadr_d;
  logic [M-1:0] outadr_q, outadr_d;
  logic         rd_in_q, rd_in_d;
  logic         sh_q, sh_d;
  logic         load_q, load_d;
  logic         wr_out_q, wr_out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [3:0]   last_k;
  logic [3:0]   j;
  logic [1:0]   kx, ky;

  always_comb begin
`ifdef CONV_COL_REUSE_EN
    last_k = (c_q != '0) ? 4'd2 : 4'd8;
`else
    last_k = 4'd8;
`endif
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start && in_full) begin
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (k_q == last_k) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DRAIN: state_d = CALC;
      CALC:  state_d = WRITE;
      WRITE: begin
        k_d = '0;
        if (c_q < RC_MAX) begin
          c_d     = c_q + 1'b1;
          state_d = FETCH;
        end else if (r_q < RC_MAX) begin
          c_d     = '0;
          r_d     = r_q + 1'b1;
          state_d = FETCH;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reuse fetches start at column kx=2, i.e. fetch index 6 of the full column-major order.
  always_comb begin
`ifdef CONV_COL_REUSE_EN
    j = (c_d != '0) ? (k_d + 4'd6) : k_d;
`else
    j = k_d;
`endif
  end

  always_comb begin
    kx = 2'd0;
    ky = 2'd0;
    case (j)
      4'd0: begin kx = 2'd0; ky = 2'd0; end
      4'd1: begin kx = 2'd0; ky = 2'd1; end
      4'd2: begin kx = 2'd0; ky = 2'd2; end
      4'd3: begin kx = 2'd1; ky = 2'd0; end
      4'd4: begin kx = 2'd1; ky = 2'd1; end
      4'd5: begin kx = 2'd1; ky = 2'd2; end
      4'd6: begin kx = 2'd2; ky = 2'd0; end
      4'd7: begin kx = 2'd2; ky = 2'd1; end
      4'd8: begin kx = 2'd2; ky = 2'd2; end
      default: begin kx = 2'd0; ky = 2'd0; end
    endcase
  end

  // Outputs are computed from the next state so they are registered yet aligned with it.
  always_comb begin
    rd_in_d  = (state_d == FETCH);
    pixadr_d = pixadr_q;
    if (rd_in_d) begin
      pixadr_d = (r_d + M'(ky)) * P_W + c_d + M'(kx);
    end
    wr_out_d = (state_d == WRITE);
    outadr_d = outadr_q;
    if (wr_out_d) begin
      outadr_d = r_d * OUT_W + c_d;
    end
    sh_d   = rd_in_q;
    load_d = (state_d == CALC);
    busy_d = (state_d == FETCH) || (state_d == DRAIN) ||
             (state_d == CALC)  || (state_d == WRITE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      pixadr_q <= '0;
      outadr_q <= '0;
      rd_in_q  <= 1'b0;
      sh_q     <= 1'b0;
      load_q   <= 1'b0;
      wr_out_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      pixadr_q <= pixadr_d;
      outadr_q <= outadr_d;
      rd_in_q  <= rd_in_d;
      sh_q     <= sh_d;
      load_q   <= load_d;
      wr_out_q <= wr_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pixadr = pixadr_q;
  assign outadr = outadr_q;
  assign rd_in  = rd_in_q;
  assign sh     = sh_q;
  assign load   = load_q;
  assign wr_out = wr_out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: handshake table, reset abort, hand-written first-window table,
// and randomized-noise passes checked cycle by cycle against a sequence model.
module tb_conv_window_scheduler;

  localparam int P = 5;
  localparam int M = 6;
`ifdef CONV_COL_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam int PASS_LEN = REUSE ? ((P-2)*(12 + 6*(P-3)) + 1) : (12*(P-2)*(P-2) + 1);

  logic         clk = 1'b0;
  logic         rst, start, in_full;
  logic [M-1:0] pixadr, outadr;
  logic         rd_in, sh, load, wr_out, busy, done;

  conv_window_scheduler #(.P(P), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .in_full(in_full),
    .pixadr(pixadr), .rd_in(rd_in), .sh(sh), .load(load),
    .wr_out(wr_out), .outadr(outadr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit rd; int pa; bit sh; bit ld; bit wr; int oa; bit bz; bit dn;
  } cyc_t;
  cyc_t exp_q[$];

  typedef struct { bit st; bit fl; bit exp_busy; bit exp_rd; } hs_t;
  typedef struct { bit rd; int pa; bit sh; bit ld; bit wr; } win_t;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cyc_t mk(bit rd, int pa, bit ld, bit wr, int oa, bit bz, bit dn);
    cyc_t e;
    e.rd = rd; e.pa = pa; e.sh = 1'b0; e.ld = ld; e.wr = wr; e.oa = oa; e.bz = bz; e.dn = dn;
    return e;
  endfunction

  // Expected per-cycle outputs of a whole pass, starting at the first read cycle.
  task automatic build_model();
    exp_q.delete();
    for (int r = 0; r <= P-3; r++) begin
      for (int c = 0; c <= P-3; c++) begin
        int kx0;
        kx0 = (REUSE && c > 0) ? 2 : 0;
        for (int kx = kx0; kx < 3; kx++)
          for (int ky = 0; ky < 3; ky++)
            exp_q.push_back(mk(1, (r+ky)*P + c + kx, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 1, r*(P-2) + c, 1, 0));
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    for (int i = 1; i < exp_q.size(); i++) exp_q[i].sh = exp_q[i-1].rd;
  endtask

  task automatic run_model_pass(input bit started, input bit noise, input string tag);
    int wr_cnt;
    int done_at;
    wr_cnt = 0;
    done_at = -1;
    if (!started) begin
      start = 1'b1; in_full = 1'b1;
      step();
    end
    if (!noise) start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_rd_in"}, int'(rd_in), int'(exp_q[i].rd));
      if (exp_q[i].rd) chk({tag, "_pixadr"}, int'(pixadr), exp_q[i].pa);
      chk({tag, "_sh"}, int'(sh), int'(exp_q[i].sh));
      chk({tag, "_load"}, int'(load), int'(exp_q[i].ld));
      chk({tag, "_wr_out"}, int'(wr_out), int'(exp_q[i].wr));
      if (exp_q[i].wr) chk({tag, "_outadr"}, int'(outadr), exp_q[i].oa);
      chk({tag, "_busy"}, int'(busy), int'(exp_q[i].bz));
      chk({tag, "_done"}, int'(done), int'(exp_q[i].dn));
      if (wr_out) wr_cnt++;
      if (done && done_at < 0) done_at = i + 1;
      if (i < exp_q.size() - 1) begin
        if (noise) begin
          start   = 1'($urandom_range(0, 1));
          in_full = 1'($urandom_range(0, 1));
        end
        step();
      end
    end
    chk({tag, "_wr_count"}, wr_cnt, (P-2)*(P-2));
    chk({tag, "_pass_len"}, done_at, PASS_LEN);
  endtask

  hs_t  hs_tab[5];
  win_t win_tab[12];
  int   wcyc;
  int   done_seen;

  initial begin
    hs_tab[0] = '{1, 0, 0, 0};
    hs_tab[1] = '{0, 1, 0, 0};
    hs_tab[2] = '{0, 0, 0, 0};
    hs_tab[3] = '{1, 0, 0, 0};
    hs_tab[4] = '{1, 1, 1, 1};

    win_tab[0]  = '{1,  0, 0, 0, 0};
    win_tab[1]  = '{1,  5, 1, 0, 0};
    win_tab[2]  = '{1, 10, 1, 0, 0};
    win_tab[3]  = '{1,  1, 1, 0, 0};
    win_tab[4]  = '{1,  6, 1, 0, 0};
    win_tab[5]  = '{1, 11, 1, 0, 0};
    win_tab[6]  = '{1,  2, 1, 0, 0};
    win_tab[7]  = '{1,  7, 1, 0, 0};
    win_tab[8]  = '{1, 12, 1, 0, 0};
    win_tab[9]  = '{0,  0, 1, 0, 0};
    win_tab[10] = '{0,  0, 0, 1, 0};
    win_tab[11] = '{0,  0, 0, 0, 1};

    rst = 1'b0; start = 1'b0; in_full = 1'b0;
    step(); step();
    chk("reset_pixadr", int'(pixadr), 0);
    chk("reset_outadr", int'(outadr), 0);
    chk("reset_rd_in",  int'(rd_in), 0);
    chk("reset_sh",     int'(sh), 0);
    chk("reset_load",   int'(load), 0);
    chk("reset_wr_out", int'(wr_out), 0);
    chk("reset_busy",   int'(busy), 0);
    chk("reset_done",   int'(done), 0);
    rst = 1'b1;
    step();

    // Start is only taken together with in_full; last entry launches a pass.
    foreach (hs_tab[i]) begin
      start = hs_tab[i].st; in_full = hs_tab[i].fl;
      step();
      chk("hs_busy",  int'(busy),  int'(hs_tab[i].exp_busy));
      chk("hs_rd_in", int'(rd_in), int'(hs_tab[i].exp_rd));
      if (hs_tab[i].exp_rd) chk("hs_pixadr", int'(pixadr), 0);
    end
    start = 1'b0;

    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) done_seen++;
    end
    rst = 1'b0;
    step();
    if (done) done_seen++;
    step();
    if (done) done_seen++;
    chk("abort_pixadr", int'(pixadr), 0);
    chk("abort_outadr", int'(outadr), 0);
    chk("abort_strobes", int'({rd_in, sh, load, wr_out}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_done", done_seen, 0);
    rst = 1'b1;
    step();
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_rd", int'(rd_in), 0);

    // First output window against hand-derived values.
    start = 1'b1; in_full = 1'b1;
    step();
    start = 1'b0;
    foreach (win_tab[i]) begin
      chk("win_rd_in", int'(rd_in), int'(win_tab[i].rd));
      if (win_tab[i].rd) chk("win_pixadr", int'(pixadr), win_tab[i].pa);
      chk("win_sh",     int'(sh),     int'(win_tab[i].sh));
      chk("win_load",   int'(load),   int'(win_tab[i].ld));
      chk("win_wr_out", int'(wr_out), int'(win_tab[i].wr));
      if (win_tab[i].wr) chk("win_outadr", int'(outadr), 0);
      chk("win_busy",   int'(busy),   1);
      if (i < 11) step();
    end
    wcyc = 12;
    while (!done && wcyc < 400) begin
      step();
      wcyc++;
    end
    chk("win_done_seen", int'(done), 1);
    chk("win_pass_len", wcyc, PASS_LEN);
    chk("win_fin_busy", int'(busy), 0);
    step();
    chk("win_idle_busy", int'(busy), 0);

    build_model();
    run_model_pass(1'b0, 1'b1, "rand1");

    // Back-to-back: start held high through FIN is taken on the first IDLE cycle.
    start = 1'b1; in_full = 1'b1;
    step();
    chk("b2b_idle_busy", int'(busy), 0);
    chk("b2b_idle_rd", int'(rd_in), 0);
    step();
    run_model_pass(1'b1, 1'b1, "rand2");
    start = 1'b0;
    step();
    chk("end_idle_busy", int'(busy), 0);
    chk("end_idle_done", int'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
